// File: rtl/uart_transceiver_if.sv
// Peripheral-side register bus of the UART transceiver.
// master = Peripheral register block, slave = uart_transceiver.
interface uart_transceiver_if;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       rx_err;
    logic [7:0] tx_data;
    logic       tx_start;
    logic       tx_busy;

    modport master (
        input  rx_data,
        input  rx_valid,
        input  rx_err,
        output tx_data,
        output tx_start,
        input  tx_busy
    );

    modport slave (
        output rx_data,
        output rx_valid,
        output rx_err,
        input  tx_data,
        input  tx_start,
        output tx_busy
    );
endinterface

// File: rtl/uart_transceiver.sv
// Full-duplex 8N1 UART: 16x oversampled receiver on a shared tick and an
// independent cycle-timed transmitter.
module uart_transceiver #(
    parameter int unsigned TICK_DIV = 651
) (
    input  logic                 sysclk,
    input  logic                 reset,
    input  logic                 UART_RX,
    output logic                 UART_TX,
    uart_transceiver_if.slave    bus
);

    localparam int unsigned BitCycles = 16 * TICK_DIV;
    localparam logic [15:0] TickLast  = 16'(TICK_DIV - 1);
    localparam logic [19:0] BitLast   = 20'(BitCycles - 1);

    // ---------------------------------------------------------------
    // Tick generator and RX synchronizer
    // ---------------------------------------------------------------
    logic [15:0] tick_cnt_q;
    logic        tick;

    assign tick = (tick_cnt_q == TickLast);

    always_ff @(posedge sysclk) begin
        if (reset) begin
            tick_cnt_q <= '0;
        end else if (tick) begin
            tick_cnt_q <= '0;
        end else begin
            tick_cnt_q <= tick_cnt_q + 16'd1;
        end
    end

    logic rx_meta_q;
    logic rxs_q;

    always_ff @(posedge sysclk) begin
        if (reset) begin
            rx_meta_q <= 1'b1;
            rxs_q     <= 1'b1;
        end else begin
            rx_meta_q <= UART_RX;
            rxs_q     <= rx_meta_q;
        end
    end

    // ---------------------------------------------------------------
    // Receiver
    // ---------------------------------------------------------------
    typedef enum logic [1:0] {RxIdle, RxStart, RxData, RxStop} rx_state_e;

    rx_state_e  rx_state_q, rx_state_d;
    logic [3:0] rx_cnt_q, rx_cnt_d;
    logic [2:0] rx_bit_q, rx_bit_d;
    logic [7:0] rx_shift_q, rx_shift_d;
    logic [7:0] rx_data_q, rx_data_d;
    logic       rx_valid_q, rx_valid_d;
    logic       rx_err_q, rx_err_d;

    always_ff @(posedge sysclk) begin
        if (reset) begin
            rx_state_q <= RxIdle;
            rx_cnt_q   <= '0;
            rx_bit_q   <= '0;
            rx_shift_q <= '0;
            rx_data_q  <= '0;
            rx_valid_q <= 1'b0;
            rx_err_q   <= 1'b0;
        end else begin
            rx_state_q <= rx_state_d;
            rx_cnt_q   <= rx_cnt_d;
            rx_bit_q   <= rx_bit_d;
            rx_shift_q <= rx_shift_d;
            rx_data_q  <= rx_data_d;
            rx_valid_q <= rx_valid_d;
            rx_err_q   <= rx_err_d;
        end
    end

    always_comb begin
        rx_state_d = rx_state_q;
        rx_cnt_d   = rx_cnt_q;
        rx_bit_d   = rx_bit_q;
        rx_shift_d = rx_shift_q;
        rx_data_d  = rx_data_q;
        rx_valid_d = 1'b0;
        rx_err_d   = 1'b0;
        if (tick) begin
            unique case (rx_state_q)
                RxIdle: begin
                    if (!rxs_q) begin
                        rx_state_d = RxStart;
                        rx_cnt_d   = '0;
                    end
                end
                RxStart: begin
                    // Mid start bit: a line already back high was only a glitch.
                    if (rx_cnt_q == 4'd7) begin
                        rx_cnt_d   = '0;
                        rx_bit_d   = '0;
                        rx_state_d = rxs_q ? RxIdle : RxData;
                    end else begin
                        rx_cnt_d = rx_cnt_q + 4'd1;
                    end
                end
                RxData: begin
                    if (rx_cnt_q == 4'd15) begin
                        rx_cnt_d   = '0;
                        rx_shift_d = {rxs_q, rx_shift_q[7:1]};
                        rx_bit_d   = rx_bit_q + 3'd1;
                        if (rx_bit_q == 3'd7) begin
                            rx_state_d = RxStop;
                        end
                    end else begin
                        rx_cnt_d = rx_cnt_q + 4'd1;
                    end
                end
                RxStop: begin
                    if (rx_cnt_q == 4'd15) begin
                        rx_cnt_d   = '0;
                        rx_state_d = RxIdle;
                        if (rxs_q) begin
                            rx_data_d  = rx_shift_q;
                            rx_valid_d = 1'b1;
                        end else begin
                            rx_err_d = 1'b1;
                        end
                    end else begin
                        rx_cnt_d = rx_cnt_q + 4'd1;
                    end
                end
                default: rx_state_d = RxIdle;
            endcase
        end
    end

    assign bus.rx_data  = rx_data_q;
    assign bus.rx_valid = rx_valid_q;
    assign bus.rx_err   = rx_err_q;

    // ---------------------------------------------------------------
    // Transmitter
    // ---------------------------------------------------------------
    typedef enum logic [1:0] {TxIdle, TxStart, TxData, TxStop} tx_state_e;

    tx_state_e   tx_state_q, tx_state_d;
    logic [19:0] tx_cnt_q, tx_cnt_d;
    logic [2:0]  tx_bit_q, tx_bit_d;
    logic [7:0]  tx_shift_q, tx_shift_d;
    logic        tx_out_q, tx_out_d;
    logic        bit_end;

    assign bit_end = (tx_cnt_q == BitLast);

    always_ff @(posedge sysclk) begin
        if (reset) begin
            tx_state_q <= TxIdle;
            tx_cnt_q   <= '0;
            tx_bit_q   <= '0;
            tx_shift_q <= '0;
            tx_out_q   <= 1'b1;
        end else begin
            tx_state_q <= tx_state_d;
            tx_cnt_q   <= tx_cnt_d;
            tx_bit_q   <= tx_bit_d;
            tx_shift_q <= tx_shift_d;
            tx_out_q   <= tx_out_d;
        end
    end

    always_comb begin
        tx_state_d = tx_state_q;
        tx_cnt_d   = tx_cnt_q;
        tx_bit_d   = tx_bit_q;
        tx_shift_d = tx_shift_q;
        tx_out_d   = tx_out_q;
        unique case (tx_state_q)
            TxIdle: begin
                // The start bit is driven from the accept edge onward.
                if (bus.tx_start) begin
                    tx_shift_d = bus.tx_data;
                    tx_cnt_d   = '0;
                    tx_out_d   = 1'b0;
                    tx_state_d = TxStart;
                end
            end
            TxStart: begin
                if (bit_end) begin
                    tx_cnt_d   = '0;
                    tx_bit_d   = '0;
                    tx_out_d   = tx_shift_q[0];
                    tx_state_d = TxData;
                end else begin
                    tx_cnt_d = tx_cnt_q + 20'd1;
                end
            end
            TxData: begin
                if (bit_end) begin
                    tx_cnt_d = '0;
                    if (tx_bit_q == 3'd7) begin
                        tx_out_d   = 1'b1;
                        tx_state_d = TxStop;
                    end else begin
                        tx_shift_d = {1'b0, tx_shift_q[7:1]};
                        tx_out_d   = tx_shift_q[1];
                        tx_bit_d   = tx_bit_q + 3'd1;
                    end
                end else begin
                    tx_cnt_d = tx_cnt_q + 20'd1;
                end
            end
            TxStop: begin
                if (bit_end) begin
                    tx_cnt_d   = '0;
                    tx_state_d = TxIdle;
                end else begin
                    tx_cnt_d = tx_cnt_q + 20'd1;
                end
            end
            default: tx_state_d = TxIdle;
        endcase
    end

    assign bus.tx_busy = (tx_state_q != TxIdle);
    assign UART_TX     = tx_out_q;

endmodule

// File: doc/uart_transceiver.md
# uart_transceiver

Full-duplex 8N1 serial port behind the Peripheral block's UART registers; it drives the board `UART_TX` pin and samples `UART_RX`. The receive side oversamples at 16× baud, recovers bytes and reports them to Peripheral with one-cycle strobes. The transmit side serialises one byte per `tx_start` request. Peripheral handles register decode and IRQ generation; this block handles only the serial link.

## Interface
- `TICK_DIV`, 651: `sysclk` cycles per 1/16 bit (100 MHz / (9600 × 16)); legal range 2..65535.
- `sysclk`  in  1  system clock; all logic is on its rising edge.
- `reset`  in  1  synchronous, active-high.
- `UART_RX`  in  1  asynchronous serial input, idle high.
- `rx_data`  out  8  last correctly framed received byte.
- `rx_valid`  out  1  one-cycle strobe: `rx_data` was just updated.
- `rx_err`  out  1  one-cycle strobe: framing error (stop bit sampled 0).
- `tx_data`  in  8  byte to transmit; sampled at accept.
- `tx_start`  in  1  transmit request; level-sampled.
- `tx_busy`  out  1  high from accept until the stop bit completes.
- `UART_TX`  out  1  registered serial output, idle high.

## Operation
- Reset values: `rx_data`=0, `rx_valid`=0, `rx_err`=0, `tx_busy`=0, `UART_TX`=1. Both FSMs go to IDLE, all counters go to 0, and both synchronizer flops go to 1.
- Tick generator: a free-running counter runs 0..TICK_DIV-1. `tick` is high in the cycle the counter equals TICK_DIV-1, and the counter wraps to 0 on the next edge.
- RX input passes through a 2-flop synchronizer (`rxs`). All RX decisions use `rxs` and are taken only on `tick` cycles.
- RX FSM:
  - IDLE: on a tick with `rxs`=0, go to START and clear the sample count.
  - START: count ticks. At count 7 (mid start bit), go to DATA if `rxs`=0; otherwise treat it as a glitch and return to IDLE. The count clears on the transition.
  - DATA: sample `rxs` every 16th tick, LSB first, into a shift register. After bit 7, go to STOP.
  - STOP: sample at the 16th tick. If 1, load `rx_data` from the shift register and pulse `rx_valid`. If 0, pulse `rx_err` and leave `rx_data` unchanged. Return to IDLE in both cases.
  - `rx_valid` and `rx_err` are never high together.
- TX FSM:
  - IDLE: accept when `tx_start`=1 and `tx_busy`=0. Latch `tx_data`, set `tx_busy`, and go to START.
  - START → DATA (8 bits, LSB first) → STOP → IDLE.
  - Each bit lasts exactly 16×TICK_DIV cycles, timed by a private cycle counter that clears at accept. The TX side does not use the shared tick.
  - `tx_start` while `tx_busy`=1 is ignored; no queuing.
  - `tx_data` changes after accept do not affect the frame in flight.

## Timing
- TX: accept at edge k. At edge k+1, `UART_TX`=0 and `tx_busy`=1.
- TX frame length is 160×TICK_DIV cycles. `tx_busy` falls on the same edge that ends the stop bit.
- `tx_start` held high produces back-to-back frames. Accept happens in the first cycle `tx_busy`=0, so each stop bit lasts 16×TICK_DIV+1 cycles.
- RX: `rx_valid`/`rx_err` rise on the edge after the STOP sample tick and last exactly one cycle.
- RX end-to-end latency from a line edge is 2 cycles of synchronizer plus up to TICK_DIV cycles of tick phase uncertainty.
- RX and TX run independently; simultaneous receive and transmit is required.
- Reset asserted mid-frame:
  - `UART_TX`=1 and `tx_busy`=0 on the next edge.
  - A partially received byte is discarded, and no strobe is issued for it.
- A start bit arriving while RX is in STOP is not lost. RX returns to IDLE after the STOP sample and detects the next falling edge on a following tick.

## Test plan
- TICK_DIV=4, TX only: pulse `tx_start` with `tx_data`=8'hA5.
  - `UART_TX` shows 0,1,0,1,0,0,1,0,1,1, 64 cycles per bit.
  - `tx_busy` is high for exactly 640 cycles.
- Loopback (`UART_TX`→`UART_RX`), TICK_DIV=4: send 8'h00, 8'hFF, 8'h3C back-to-back with `tx_start` held high.
  - Exactly three `rx_valid` pulses, with `rx_data` 00, FF, 3C.
  - `rx_err` never asserts.
- Framing error: drive a frame of 8'h55 with a stop bit of 0.
  - `rx_err` pulses once and `rx_valid` stays 0.
  - `rx_data` keeps its prior value.
- Glitch rejection: a 0-pulse on `UART_RX` of 3 ticks (12 cycles at TICK_DIV=4).
  - No strobe is produced and RX returns to IDLE.
  - A subsequent valid 8'h81 frame is received correctly.
- Busy rule: assert `tx_start` with 8'h11, then pulse `tx_start` with 8'h22 while `tx_busy`=1.
  - Only the 8'h11 frame is emitted.
- Reset at bit 4 of a TX frame and of an RX frame.
  - Next cycle: `UART_TX`=1, `tx_busy`=0, no RX strobe.
  - A following 8'h5A frame is transmitted and received correctly.
